// File: rtl/mode_transition_sequencer_if.sv
// mode_transition_sequencer_if: requester/control bundle between requesters, sequencer and downstream mode FSM
interface mode_transition_sequencer_if;
  logic [1:0] req_valid;
  logic [2:0] req_mode0;
  logic [2:0] req_mode1;
  logic [1:0] ack;
  logic [1:0] err;
  logic [1:0] err_code;
  logic [2:0] cur_mode;
  logic [3:0] ctrl_out;
  logic       ctrl_strobe;
  logic       busy;
  logic [7:0] err_count;
  modport master (
    output req_valid, req_mode0, req_mode1,
    input  ack, err, err_code, cur_mode, ctrl_out, ctrl_strobe, busy, err_count
  );
  modport slave (
    input  req_valid, req_mode0, req_mode1,
    output ack, err, err_code, cur_mode, ctrl_out, ctrl_strobe, busy, err_count
  );
endinterface

// File: rtl/mode_transition_sequencer.sv
// mode_transition_sequencer: round-robin gatekeeper for mode changes; define MODE_SEQ_ERR_COUNT_EN for the saturating error counter
module mode_transition_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter bit RR_INIT       = 1'b0
) (
  input logic clk,
  input logic rst,
  mode_transition_sequencer_if.slave bus
);
  typedef enum logic [1:0] {ARB, RESP, SETTLE} state_t;
  localparam logic [2:0] IDLE = 3'd0, INIT = 3'd1, CONFIG = 3'd2, RUN = 3'd3, LOCK = 3'd4;
  state_t     state, nxt;
  logic       ptr;
  logic [7:0] cnt;
  logic [1:0] ack_r, err_r, code_r;
  logic [2:0] mode_r;
  logic [3:0] ctrl_r;
  logic       strobe_r, busy_r;
  logic       grant, both, g, change;
  logic [2:0] tgt;
  logic [1:0] code;
  function automatic logic [3:0] ctrl_map(input logic [2:0] m);
    return m == INIT ? 4'h1 : m == CONFIG ? 4'hC : m == RUN ? 4'h3 : m == LOCK ? 4'h8 : 4'h0;
  endfunction
  function automatic logic legal(input logic [2:0] cur, input logic [2:0] t);
    return (cur == IDLE && t == INIT) || (cur == INIT && t == CONFIG) ||
           (cur == CONFIG && t == RUN) || (cur == RUN && (t == CONFIG || t == LOCK)) ||
           (t == IDLE && cur != LOCK);
  endfunction
  // arbitration and legality decode of the granted request; only meaningful in ARB
  always_comb begin
    both   = &bus.req_valid;
    grant  = state == ARB && |bus.req_valid;
    g      = both ? ptr : bus.req_valid[1];
    tgt    = g ? bus.req_mode1 : bus.req_mode0;
    code   = mode_r == LOCK ? (tgt == LOCK ? 2'd0 : 2'd3) :
             tgt > LOCK ? 2'd2 :
             tgt == mode_r ? 2'd0 :
             legal(mode_r, tgt) ? 2'd0 : 2'd1;
    change = code == 2'd0 && tgt != mode_r;
  end
  // controller state register
  always_ff @(posedge clk)
    state <= rst ? ARB : nxt;
  // next-state: commits settle, no-ops and rejections take one dead cycle
  always_comb begin
    nxt = state == ARB ? (!grant ? ARB : change ? SETTLE : RESP) :
          state == RESP ? ARB :
          cnt == 8'd0 ? ARB : SETTLE;
  end
  // registered outputs: pulses default low, mode and control word move only on a committed change
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= RR_INIT;
      cnt      <= '0;
      ack_r    <= '0;
      err_r    <= '0;
      code_r   <= '0;
      mode_r   <= IDLE;
      ctrl_r   <= 4'h0;
      strobe_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      ack_r    <= '0;
      err_r    <= '0;
      strobe_r <= 1'b0;
      if (grant) begin
        if (both) ptr <= ~ptr;
        if (code != 2'd0) begin
          err_r  <= g ? 2'b10 : 2'b01;
          code_r <= code;
        end else begin
          ack_r <= g ? 2'b10 : 2'b01;
          if (change) begin
            mode_r   <= tgt;
            ctrl_r   <= ctrl_map(tgt);
            strobe_r <= 1'b1;
            busy_r   <= 1'b1;
            cnt      <= 8'(SETTLE_CYCLES - 1);
          end
        end
      end else if (state == SETTLE) begin
        if (cnt == 8'd0) busy_r <= 1'b0;
        else cnt <= cnt - 8'd1;
      end
    end
  end
`ifdef MODE_SEQ_ERR_COUNT_EN
  logic [7:0] err_cnt_r;
  // saturating count of rejections, advanced on the edge that raises err
  always_ff @(posedge clk)
    err_cnt_r <= rst ? 8'h00 : (grant && code != 2'd0 && err_cnt_r != 8'hFF) ? err_cnt_r + 8'd1 : err_cnt_r;
  assign bus.err_count = err_cnt_r;
`else
  assign bus.err_count = 8'h00;
`endif
  assign bus.ack         = ack_r;
  assign bus.err         = err_r;
  assign bus.err_code    = code_r;
  assign bus.cur_mode    = mode_r;
  assign bus.ctrl_out    = ctrl_r;
  assign bus.ctrl_strobe = strobe_r;
  assign bus.busy        = busy_r;
endmodule

// File: tb/tb_mode_transition_sequencer.sv
// tb_mode_transition_sequencer: directed self-checking bench for mode_transition_sequencer (SETTLE_CYCLES=4, RR_INIT=0)
module tb_mode_transition_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int n_pulses;
  mode_transition_sequencer_if bus ();
  mode_transition_sequencer #(.SETTLE_CYCLES(4), .RR_INIT(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic [1:0] v, input logic [2:0] m0, input logic [2:0] m1);
    bus.req_valid = v;
    bus.req_mode0 = m0;
    bus.req_mode1 = m1;
  endtask
  task automatic expect_out(input string tag, input logic [1:0] a, input logic [1:0] e, input logic s,
                            input logic b, input logic [2:0] m, input logic [3:0] c);
    chk({tag, ".ack"}, 8'(bus.ack), 8'(a));
    chk({tag, ".err"}, 8'(bus.err), 8'(e));
    chk({tag, ".strobe"}, 8'(bus.ctrl_strobe), 8'(s));
    chk({tag, ".busy"}, 8'(bus.busy), 8'(b));
    chk({tag, ".mode"}, 8'(bus.cur_mode), 8'(m));
    chk({tag, ".ctrl"}, 8'(bus.ctrl_out), 8'(c));
  endtask
  task automatic settle(input string tag, input logic [2:0] m, input logic [3:0] c);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out({tag, ".hold"}, 2'b00, 2'b00, 1'b0, 1'b1, m, c);
    end
    step();
    expect_out({tag, ".done"}, 2'b00, 2'b00, 1'b0, 1'b0, m, c);
  endtask
  initial begin
    req(2'b00, 3'd0, 3'd0);
    step();
    step();
    expect_out("reset", 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 4'h0);
    chk("reset.code", 8'(bus.err_code), 8'd0);
    chk("reset.errcnt", bus.err_count, 8'h00);
    rst = 1'b0;
    // illegal transition and invalid code from IDLE
    req(2'b10, 3'd0, 3'd3);
    step();
    expect_out("ill_run", 2'b00, 2'b10, 1'b0, 1'b0, 3'd0, 4'h0);
    chk("ill_run.code", 8'(bus.err_code), 8'd1);
    req(2'b00, 3'd0, 3'd0);
    step();
    expect_out("ill_run.resp", 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 4'h0);
    req(2'b01, 3'd6, 3'd0);
    step();
    expect_out("bad_code", 2'b00, 2'b01, 1'b0, 1'b0, 3'd0, 4'h0);
    chk("bad_code.code", 8'(bus.err_code), 8'd2);
    req(2'b00, 3'd0, 3'd0);
    step();
    // legal walk IDLE->INIT->CONFIG->RUN via requester 0
    req(2'b01, 3'd1, 3'd0);
    step();
    expect_out("to_init", 2'b01, 2'b00, 1'b1, 1'b1, 3'd1, 4'h1);
    req(2'b00, 3'd0, 3'd0);
    settle("to_init", 3'd1, 4'h1);
    req(2'b01, 3'd2, 3'd0);
    step();
    expect_out("to_config", 2'b01, 2'b00, 1'b1, 1'b1, 3'd2, 4'hC);
    req(2'b00, 3'd0, 3'd0);
    settle("to_config", 3'd2, 4'hC);
    req(2'b01, 3'd3, 3'd0);
    step();
    expect_out("to_run", 2'b01, 2'b00, 1'b1, 1'b1, 3'd3, 4'h3);
    req(2'b00, 3'd0, 3'd0);
    settle("to_run", 3'd3, 4'h3);
    // RUN->LOCK via requester 1, then LOCK rejects everything but reset
    req(2'b10, 3'd0, 3'd4);
    step();
    expect_out("to_lock", 2'b10, 2'b00, 1'b1, 1'b1, 3'd4, 4'h8);
    req(2'b00, 3'd0, 3'd0);
    settle("to_lock", 3'd4, 4'h8);
    req(2'b01, 3'd0, 3'd0);
    step();
    expect_out("lock_idle", 2'b00, 2'b01, 1'b0, 1'b0, 3'd4, 4'h8);
    chk("lock_idle.code", 8'(bus.err_code), 8'd3);
    req(2'b00, 3'd0, 3'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_out("lock_rst", 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 4'h0);
    chk("lock_rst.code", 8'(bus.err_code), 8'd0);
    // contention: pointer starts at 0, then alternates
    req(2'b11, 3'd1, 3'd0);
    step();
    expect_out("rr_first", 2'b01, 2'b00, 1'b1, 1'b1, 3'd1, 4'h1);
    req(2'b10, 3'd1, 3'd0);
    settle("rr_first", 3'd1, 4'h1);
    step();
    expect_out("rr_second", 2'b10, 2'b00, 1'b1, 1'b1, 3'd0, 4'h0);
    req(2'b00, 3'd0, 3'd0);
    settle("rr_second", 3'd0, 4'h0);
    req(2'b11, 3'd1, 3'd1);
    step();
    expect_out("rr_alt", 2'b10, 2'b00, 1'b1, 1'b1, 3'd1, 4'h1);
    req(2'b01, 3'd1, 3'd0);
    settle("rr_alt", 3'd1, 4'h1);
    step();
    expect_out("rr_noop", 2'b01, 2'b00, 1'b0, 1'b0, 3'd1, 4'h1);
    req(2'b00, 3'd0, 3'd0);
    step();
    expect_out("rr_noop.resp", 2'b00, 2'b00, 1'b0, 1'b0, 3'd1, 4'h1);
    // reset on the second SETTLE cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    req(2'b01, 3'd1, 3'd0);
    step();
    expect_out("mid_commit", 2'b01, 2'b00, 1'b1, 1'b1, 3'd1, 4'h1);
    req(2'b00, 3'd0, 3'd0);
    step();
    expect_out("mid_settle2", 2'b00, 2'b00, 1'b0, 1'b1, 3'd1, 4'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_out("mid_rst", 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 4'h0);
    step();
    expect_out("mid_quiet", 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 4'h0);
    req(2'b01, 3'd1, 3'd0);
    step();
    expect_out("mid_arb", 2'b01, 2'b00, 1'b1, 1'b1, 3'd1, 4'h1);
    req(2'b00, 3'd0, 3'd0);
    settle("mid_arb", 3'd1, 4'h1);
    // 300 rejections: counter saturates when enabled, stays zero otherwise
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_pulses = 0;
    req(2'b01, 3'd7, 3'd0);
    for (int i = 0; i < 600; i++) begin
      step();
      if (bus.err == 2'b01) n_pulses++;
    end
    req(2'b00, 3'd0, 3'd0);
    step();
    chk("errcnt.pulses", 8'(n_pulses == 300), 8'd1);
    chk("errcnt.mode", 8'(bus.cur_mode), 8'd0);
`ifdef MODE_SEQ_ERR_COUNT_EN
    chk("errcnt.value", bus.err_count, 8'hFF);
`else
    chk("errcnt.value", bus.err_count, 8'h00);
`endif
    rst = 1'b1;
    step();
    chk("errcnt.rst", bus.err_count, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mode_transition_sequencer.md
Name: mode_transition_sequencer

Overview:
- Gatekeeper and scheduler in front of the 4-bit-control mode FSM.
- Two requesters ask for mode changes. The block arbitrates between them round-robin and checks each request against a fixed legal-transition table.
- Only legal transitions reach the downstream FSM, as a registered 4-bit control word and a one-cycle strobe, followed by a settle window. Illegal requests are rejected with an error code, and the current mode does not change.

Parameters:
- SETTLE_CYCLES, 4, cycles `busy` stays high after a committed transition (legal range 1..255).
- RR_INIT, 0, requester with priority first after reset (0 or 1).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  2  per-requester request valid; requester holds it until `ack` or `err` for that index
- req_mode0  input  3  target mode code, requester 0
- req_mode1  input  3  target mode code, requester 1
- ack  output  2  one-cycle pulse: request accepted
- err  output  2  one-cycle pulse: request rejected
- err_code  output  2  reason for the last rejection; valid while any `err` bit is high
- cur_mode  output  3  committed mode
- ctrl_out  output  4  control word to the downstream FSM
- ctrl_strobe  output  1  one-cycle pulse when `ctrl_out` changes
- busy  output  1  settle window active
- err_count  output  8  saturating rejection count (optional feature only)

Behaviour:
- Mode codes:
  - IDLE=0, INIT=1, CONFIG=2, RUN=3, LOCK=4.
  - Codes 5..7 are invalid.
- Legal transitions:
  - IDLE->INIT, INIT->CONFIG, CONFIG->RUN, RUN->CONFIG, RUN->LOCK.
  - Any mode except LOCK -> IDLE.
  - A request for the current mode is a legal no-op.
- `ctrl_out` mapping: IDLE=4'h0, INIT=4'h1, CONFIG=4'hC, RUN=4'h3, LOCK=4'h8. `ctrl_out` is registered and always equals map(`cur_mode`).
- Reset values: `cur_mode`=IDLE, `ctrl_out`=4'h0, `ack`=0, `err`=0, `err_code`=0, `ctrl_strobe`=0, `busy`=0, `err_count`=0. Round-robin pointer = RR_INIT. Controller state = ARB.
- Controller states: ARB, RESP, SETTLE.
- ARB:
  - Requests are sampled only in this state.
  - If exactly one `req_valid` bit is set, that requester is granted.
  - If both are set, the requester at the pointer is granted, then the pointer moves to the other requester.
  - If neither is set, the block stays in ARB.
- Grant, legal change (target != `cur_mode`), at the sampling edge:
  - `cur_mode` and `ctrl_out` update.
  - `ack[g]`, `ctrl_strobe` and `busy` are set.
  - Counter loads SETTLE_CYCLES-1; next state SETTLE.
  - `ack` and `ctrl_strobe` are visible the cycle after sampling, for exactly one cycle.
- Grant, no-op (target == `cur_mode`): `ack[g]` pulses; no strobe, no busy; next state RESP.
- Grant, illegal: `err[g]` pulses; `err_code` is set; `cur_mode` is unchanged; next state RESP. Error codes:
  - 2'd1: illegal transition.
  - 2'd2: invalid mode code (5..7).
  - 2'd3: current mode is LOCK. This code takes priority over 1 and 2.
- RESP: one dead cycle with no sampling, so the requester can drop `valid`. Then returns to ARB.
- SETTLE:
  - Counter decrements each cycle; no sampling.
  - When the counter reaches 0, `busy` clears on that edge and the next state is ARB.
  - Total time with `busy` high is SETTLE_CYCLES cycles.
- The ungranted requester is never acked or errored. Its request waits in ARB.
- LOCK is left only through `rst`.
- Reset mid-operation (SETTLE or RESP): `rst` has priority on the next edge. All outputs return to reset values and no pending pulse is emitted.

Optional Feature:
- Macro: MODE_SEQ_ERR_COUNT_EN.
- Defined: `err_count` increments on every `err` pulse and saturates at 8'hFF; it is cleared only by `rst`.
- Undefined: `err_count` is tied to 8'h00 and the counter logic is absent.

Test Plan:
- Sequence IDLE->INIT->CONFIG->RUN via requester 0 with SETTLE_CYCLES=4 -> each request gets an `ack` pulse one cycle after sampling. `ctrl_out` steps 1, C, 3 with one `ctrl_strobe` per step. `busy` is high exactly 4 cycles each time.
- From IDLE, requester 1 asks for RUN (3) -> `err`=2'b10, `err_code`=1, `cur_mode` stays 0, no `ctrl_strobe`. Requester asks for 6 -> `err_code`=2.
- Both requesters valid in ARB with RR_INIT=0 (req0=INIT, req1=IDLE) -> requester 0 is acked first. After SETTLE, requester 1 is acked (a no-op back to... transition to IDLE). The pointer alternates on the next contention.
- Reach LOCK (…->RUN->LOCK), then request IDLE -> `err_code`=3, `ctrl_out` stays 8. Assert `rst` -> `cur_mode`=0, `ctrl_out`=0.
- Assert `rst` on the 2nd cycle of SETTLE -> next cycle `busy`=0, state ARB, no stray `ack` or strobe.
- With MODE_SEQ_ERR_COUNT_EN defined, issue 300 illegal requests -> `err_count`=8'hFF. Without the macro -> `err_count` stays 0.
